maxpool_flatten: RTL and testbench
==================================

MAXPOOL_FLATTEN -- requirements
Module: maxpool_flatten

Interface
REQ-001 SHALL have parameter DATA_W, default 20, pixel width in bits (signed two's complement).
REQ-002 SHALL have parameter ADDR_W, default 12, memory address width in bits.
REQ-003 SHALL have parameter IMG_W, default 64, width and height of each layer-0 map in pixels (pooled map width IMG_W/2).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low; clears all state while low.
REQ-006 SHALL have port start, input, 1, single-cycle request to pool both layer-0 maps.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start until the last write.
REQ-008 SHALL have port crd, output, 1, read strobe to layer memories.
REQ-009 SHALL have port caddr_rd, output, ADDR_W, read address.
REQ-010 SHALL have port cdata_rd, input, DATA_W, read data, valid at the rising edge ending the cycle in which crd=1 was presented.
REQ-011 SHALL have port cwr, output, 1, write strobe, sampled by memory on the rising edge.
REQ-012 SHALL have port caddr_wr, output, ADDR_W, write address.
REQ-013 SHALL have port cdata_wr, output, DATA_W, write data.
REQ-014 SHALL have port csel, output, 3, memory select: 001 L0 map0, 010 L0 map1, 011 L1 map0, 100 L1 map1, 101 L2 flatten, 000 none.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WL1, WL2; IDLE->READ on start; READ (4 cycles, quadrant counter q=0..3)->WL1->WL2->READ for next job, or ->IDLE after final job.
REQ-016 SHALL process jobs in order: pooled pixel p=0..(IMG_W/2)^2-1 raster order, kernel k=0 then k=1 per p.
REQ-017 SHALL, in READ, drive crd=1, csel=001+k, caddr_rd = (2r)*IMG_W+2c + {0,1,IMG_W,IMG_W+1}[q], where r=p/(IMG_W/2), c=p%(IMG_W/2).
REQ-018 SHALL compare signed; q=0 sample loads the max register, q=1..3 samples replace it only if strictly greater.
REQ-019 SHALL, in WL1, drive cwr=1, csel=011+k, caddr_wr=p, cdata_wr=max; crd=0.
REQ-020 SHALL, in WL2, drive cwr=1, csel=101, caddr_wr=2p+k, cdata_wr=max; crd=0.
REQ-021 SHALL never assert crd and cwr in the same cycle; csel=000, crd=0, cwr=0 in IDLE.
REQ-022 SHALL take exactly 6 cycles per job; total busy time 12*(IMG_W/2)^2 cycles (12288 at default).
REQ-023 SHALL ignore start while busy=1; start and final WL2 coinciding is ignored (a new start is accepted only from IDLE).
REQ-024 SHALL drive busy low in the cycle after final WL2, returning to IDLE.
REQ-025 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-026 SHALL, on reset low at any time including mid-job, force IDLE, busy=0, crd=0, cwr=0, csel=000, caddr_rd=0, caddr_wr=0, cdata_wr=0, counters and max register 0.
REQ-027 SHALL not resume an interrupted run after reset release; a new start is required.

Structure
REQ-028 SHALL place csel encodings, FSM state encoding, and DATA_W/ADDR_W defaults in shared package conv_pkg.
REQ-029 SHALL use one sub-module, max4_reg (sequential signed running-max with load/update enables); address generation and FSM stay in the top.

Verification
REQ-030 Bench: L0 map0 all 0x00005, start pulse -> all 1024 L1 map0 and even L2 entries = 0x00005; busy high exactly 12288 cycles.
REQ-031 Bench: quadrant at p=0 map0 = {3,9,-2,7} -> L1_MEM0[0]=0x00009, L2[0]=0x00009; max in q=3 position (0x0000A at addr 65) -> 0x0000A.
REQ-032 Bench: map1 quadrant at p=1023 all negative {-4,-1,-8,-3} -> L1_MEM1[1023]=0xFFFFF, L2[2047]=0xFFFFF.
REQ-033 Bench: monitor every cycle -> crd&cwr never both 1; read csel in {001,010}, write csel in {011,100,101}; first READ address sequence 0,1,64,65.
REQ-034 Bench: reset low at cycle 500 of run, release, start again -> outputs zero during reset, full correct result after second run, no writes between reset and second start.
REQ-035 Bench: start pulses at cycles 10 and 200 of a run -> no effect; busy duration unchanged at 12288.

Source files
------------

// File: rtl/maxpool_flatten_pkg.sv
// Shared encodings for the pooling/flatten engine: memory selects,
// controller states and default bus widths.
package conv_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        SEL_NONE    = 3'b000,
        SEL_L0_MAP0 = 3'b001,
        SEL_L0_MAP1 = 3'b010,
        SEL_L1_MAP0 = 3'b011,
        SEL_L1_MAP1 = 3'b100,
        SEL_L2      = 3'b101
    } csel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WL1  = 2'd2,
        ST_WL2  = 2'd3
    } state_e;

    // Offset of quadrant sample q inside a 2x2 window: 0, 1, W, W+1.
    function automatic int quad_offset(input logic [1:0] q, input int img_w);
        return int'(q[0]) + (q[1] ? img_w : 0);
    endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// Layer-memory bus between the pooling engine (master) and the memories (slave).
interface maxpool_flatten_if
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );

endinterface

// File: rtl/maxpool_flatten_max4_reg.sv
// Signed running-max register: load takes the first window sample,
// update keeps the larger of the stored value and the new sample.
module max4_reg
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              update,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] max_o
);

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] max_d;

    // Next max: load wins, otherwise replace only on a strictly greater sample.
    always_comb begin
        max_d = max_q;
        if (load) begin
            max_d = din;
        end else if (update && ($signed(din) > $signed(max_q))) begin
            max_d = din;
        end
    end

    // Max register with async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_o = max_q;

endmodule

// File: rtl/maxpool_flatten.sv
// 2x2 max-pool of both layer-0 maps into layer-1 maps, interleaved into
// the layer-2 flatten buffer. One job = one pooled pixel of one kernel.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start, bus quiet
//   READ    | four reads of the 2x2 window (q = 0..3), running max
//   WL1     | write max to layer-1 map k at address p
//   WL2     | write max to layer-2 flatten buffer at address 2p+k
module maxpool_flatten
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IMG_W  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    maxpool_flatten_if.master bus
);

    localparam int HALF_W = IMG_W / 2;
    localparam int NPIX   = HALF_W * HALF_W;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;

    state_e            state_q, state_d;
    logic [1:0]        q_q, q_d;
    logic [PIX_W-1:0]  p_q, p_d;
    logic              k_q, k_d;
    logic              busy_q, busy_d;
    logic              crd_q, crd_d;
    logic              cwr_q, cwr_d;
    csel_e             csel_q, csel_d;
    logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
    logic              last_job;
    int                rd_addr;
    logic              max_load, max_update;
    logic [DATA_W-1:0] max_val;

    // Next state, job counters, and the registered bus values for the next cycle.
    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        p_d        = p_q;
        k_d        = k_q;
        last_job   = (p_q == PIX_W'(NPIX - 1)) && k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    q_d     = '0;
                    p_d     = '0;
                    k_d     = 1'b0;
                end
            end
            ST_READ: begin
                q_d = q_q + 2'd1;
                if (q_q == 2'd3) begin
                    state_d = ST_WL1;
                end
            end
            ST_WL1: state_d = ST_WL2;
            ST_WL2: begin
                if (last_job) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                    q_d     = '0;
                    if (k_q) begin
                        k_d = 1'b0;
                        p_d = p_q + 1'b1;
                    end else begin
                        k_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        crd_d      = (state_d == ST_READ);
        cwr_d      = (state_d == ST_WL1) || (state_d == ST_WL2);
        csel_d     = SEL_NONE;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        rd_addr    = 0;
        case (state_d)
            ST_READ: begin
                csel_d     = k_d ? SEL_L0_MAP1 : SEL_L0_MAP0;
                rd_addr    = 2 * (int'(p_d) / HALF_W) * IMG_W
                           + 2 * (int'(p_d) % HALF_W)
                           + quad_offset(q_d, IMG_W);
                caddr_rd_d = ADDR_W'(rd_addr);
            end
            ST_WL1: begin
                csel_d     = k_d ? SEL_L1_MAP1 : SEL_L1_MAP0;
                caddr_wr_d = ADDR_W'(p_d);
            end
            ST_WL2: begin
                csel_d     = SEL_L2;
                caddr_wr_d = ADDR_W'({p_d, k_d});
            end
            default: ;
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            p_q        <= '0;
            k_q        <= 1'b0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= SEL_NONE;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            p_q        <= p_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            csel_q     <= csel_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
        end
    end

    // Read data belongs to the read presented this cycle; capture it at the closing edge.
    assign max_load   = (state_q == ST_READ) && (q_q == 2'd0);
    assign max_update = (state_q == ST_READ) && (q_q != 2'd0);

    max4_reg #(.DATA_W(DATA_W)) u_max (
        .clk    (clk),
        .reset  (reset),
        .load   (max_load),
        .update (max_update),
        .din    (bus.cdata_rd),
        .max_o  (max_val)
    );

    assign busy         = busy_q;
    assign bus.crd      = crd_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = max_val;
    assign bus.csel     = csel_q;

endmodule

// File: tb/tb_maxpool_flatten.sv
// Bench for maxpool_flatten: behavioural memories, table-driven quadrant
// vectors, random map contents checked against a pooling model.
module tb_maxpool_flatten;
    import conv_pkg::*;

    localparam int DW       = 20;
    localparam int AW       = 12;
    localparam int IW       = 64;
    localparam int HW       = IW / 2;
    localparam int NPIX     = HW * HW;
    localparam int NL0      = IW * IW;
    localparam int BUSY_EXP = 12 * NPIX;
    localparam logic [DW-1:0] SENT = 20'hABCDE;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;

    maxpool_flatten_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    maxpool_flatten #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] l0m [2][NL0];
    logic [DW-1:0] l1m [2][NPIX];
    logic [DW-1:0] l2m [2*NPIX];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int viol = 0;
    logic [AW-1:0] first_rd [4];

    assign bus.cdata_rd = !bus.crd ? '0 :
                          (bus.csel == 3'b001) ? l0m[0][bus.caddr_rd] :
                          (bus.csel == 3'b010) ? l0m[1][bus.caddr_rd] : '0;

    // Memory writes and protocol monitor (outputs are stable mid-cycle).
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.crd && bus.cwr) viol++;
            if (bus.crd && !(bus.csel == 3'b001 || bus.csel == 3'b010)) viol++;
            if (bus.cwr && !(bus.csel == 3'b011 || bus.csel == 3'b100 || bus.csel == 3'b101)) viol++;
            if (!busy && (bus.crd || bus.cwr || bus.csel != 3'b000)) viol++;
            if (bus.cwr) begin
                wr_count++;
                case (bus.csel)
                    3'b011:  l1m[0][bus.caddr_wr[9:0]] = bus.cdata_wr;
                    3'b100:  l1m[1][bus.caddr_wr[9:0]] = bus.cdata_wr;
                    3'b101:  l2m[bus.caddr_wr[10:0]]   = bus.cdata_wr;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Max over the 2x2 block of map m covering pooled pixel p.
    function automatic logic [DW-1:0] ref_max(input int m, input int p);
        int r = p / HW;
        int c = p % HW;
        int best = int'($signed(l0m[m][(2*r)*IW + 2*c]));
        int v;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = int'($signed(l0m[m][(2*r+dy)*IW + 2*c+dx]));
                if (v > best) best = v;
            end
        end
        return DW'(best);
    endfunction

    task automatic set_quad(input int m, input int p, input int v0, input int v1,
                            input int v2, input int v3);
        int base = 2*(p/HW)*IW + 2*(p%HW);
        l0m[m][base]      = DW'(v0);
        l0m[m][base+1]    = DW'(v1);
        l0m[m][base+IW]   = DW'(v2);
        l0m[m][base+IW+1] = DW'(v3);
    endtask

    task automatic clear_out();
        for (int i = 0; i < NPIX; i++) begin
            l1m[0][i] = SENT;
            l1m[1][i] = SENT;
        end
        for (int i = 0; i < 2*NPIX; i++) l2m[i] = SENT;
    endtask

    task automatic fill_random(input int m);
        for (int i = 0; i < NL0; i++) l0m[m][i] = DW'($urandom);
    endtask

    task automatic compare_all(input string tag);
        int bad1 = 0;
        int bad2 = 0;
        logic [DW-1:0] e;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < NPIX; p++) begin
                e = ref_max(m, p);
                if (l1m[m][p] !== e) bad1++;
                if (l2m[2*p+m] !== e) bad2++;
            end
        end
        check({tag, " L1 mismatch count"}, bad1, 0);
        check({tag, " L2 mismatch count"}, bad2, 0);
    endtask

    // Pulse start, count busy cycles; optional stray starts, optional abort point.
    task automatic run_job(input bit spur, input int abort_at, output int cycles, output bit done);
        cycles = 0;
        done   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) begin
                if (cycles < 4) first_rd[cycles] = bus.caddr_rd;
                cycles++;
                if (abort_at > 0 && cycles == abort_at) break;
                if (spur && (cycles == 10 || cycles == 200 || cycles == BUSY_EXP)) start = 1'b1;
            end else if (cycles > 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int m;
        int p;
        int v0, v1, v2, v3;
        int exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  cyc;
        bit  done;
        int  n;
        int  w0;
        logic [DW-1:0] e;

        vecs[0] = '{0, 0,    3, 9, -2, 7, 9};
        vecs[1] = '{1, 1023, -4, -1, -8, -3, -1};
        vecs[2] = '{0, 33,   1, 2, 3, 10, 10};
        vecs[3] = '{1, 31,   524287, 0, -524288, 1, 524287};
        vecs[4] = '{0, 500,  -7, -7, -7, -7, -7};
        vecs[5] = '{1, 992,  -524288, -524288, -524288, -524287, -524287};

        start = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",     busy,         0);
        check("reset crd",      bus.crd,      0);
        check("reset cwr",      bus.cwr,      0);
        check("reset csel",     bus.csel,     0);
        check("reset caddr_rd", bus.caddr_rd, 0);
        check("reset caddr_wr", bus.caddr_wr, 0);
        check("reset cdata_wr", bus.cdata_wr, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Run A: constant map0, stray starts at 10, 200 and on the final write.
        for (int i = 0; i < NL0; i++) l0m[0][i] = 20'h00005;
        fill_random(1);
        clear_out();
        run_job(1'b1, 0, cyc, done);
        check("runA finished", done, 1);
        check("runA busy cycles", cyc, BUSY_EXP);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("runA start on final WL2 ignored", n, 0);
        n = 0;
        for (int p = 0; p < NPIX; p++) begin
            if (l1m[0][p] !== 20'h00005) n++;
            if (l2m[2*p] !== 20'h00005) n++;
        end
        check("runA map0 constant 5 count", n, 0);
        compare_all("runA");

        // Run B: random maps with hand-picked quadrants.
        fill_random(0);
        fill_random(1);
        foreach (vecs[i]) set_quad(vecs[i].m, vecs[i].p, vecs[i].v0, vecs[i].v1,
                                   vecs[i].v2, vecs[i].v3);
        clear_out();
        run_job(1'b0, 0, cyc, done);
        check("runB finished", done, 1);
        check("runB busy cycles", cyc, BUSY_EXP);
        check("runB first rd 0", first_rd[0], 0);
        check("runB first rd 1", first_rd[1], 1);
        check("runB first rd 2", first_rd[2], 64);
        check("runB first rd 3", first_rd[3], 65);
        foreach (vecs[i]) begin
            e = DW'(vecs[i].exp);
            check($sformatf("vec%0d L1", i), l1m[vecs[i].m][vecs[i].p], e);
            check($sformatf("vec%0d L2", i), l2m[2*vecs[i].p + vecs[i].m], e);
        end
        compare_all("runB");

        // Run C: reset mid-run, no activity until restarted, then a clean full run.
        run_job(1'b0, 500, cyc, done);
        check("runC reached abort point", cyc, 500);
        reset = 1'b0;
        #1;
        check("midreset outputs", {busy, bus.crd, bus.cwr, bus.csel, bus.caddr_rd,
                                   bus.caddr_wr, bus.cdata_wr}, 0);
        @(negedge clk);
        check("midreset outputs held", {busy, bus.crd, bus.cwr, bus.csel, bus.caddr_rd,
                                        bus.caddr_wr, bus.cdata_wr}, 0);
        reset = 1'b1;
        w0 = wr_count;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("after reset no resume busy", n, 0);
        check("after reset no writes", wr_count - w0, 0);
        set_quad(0, 0, 3, 9, -2, 10);
        clear_out();
        run_job(1'b0, 0, cyc, done);
        check("runC finished", done, 1);
        check("runC busy cycles", cyc, BUSY_EXP);
        check("runC q3 max L1", l1m[0][0], 20'h0000A);
        check("runC q3 max L2", l2m[0], 20'h0000A);
        compare_all("runC");

        check("protocol violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
